// File: rtl/exec_seq.sv
// Execute-stage sequencer: drives the combinational ALU for one or two passes per RV32I op (out_trap port under EXEC_TRAP_EN).
// Latency: out_valid two cycles after the accepting cycle for single-pass ops, three for branch/JAL/JALR.
// Backpressure: result held in HOLD until out_ready; in_ready low while executing, and in HOLD unless out_ready and ALLOW_B2B.
module exec_seq #(
    parameter logic [31:0] LINK_OFFSET = 32'd4,
    parameter int          ALLOW_B2B   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7_5,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_pc,
    output logic [2:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_br_taken,
    output logic [31:0] out_br_target,
`ifdef EXEC_TRAP_EN
    output logic        out_trap,
`endif
    output logic        out_illegal
);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRA = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {IDLE, EX1, EX2, HOLD} state_t;
    typedef enum logic [2:0] {K_ALU, K_SLT, K_SLTU, K_BR, K_JAL, K_JALR, K_ILL} kind_t;

    typedef struct packed {
        kind_t       kind;
        logic [2:0]  funct3;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] pc;
    } op_t;

    state_t      state, state_d;
    op_t         op_q, op_d;
    logic [2:0]  dec_ctrl;
    logic [31:0] dec_a, dec_b, shamt_b;
    logic        accept, two_pass;
    logic        lt_s, lt_u, br_cond, taken_q;
    logic [31:0] link_q, single_res, tgt;

    // Decode straight from the inputs so the first pass is loaded on the accept edge.
    always_comb begin
        op_d.kind   = K_ILL;
        op_d.funct3 = in_funct3;
        op_d.rs1    = in_rs1;
        op_d.imm    = in_imm;
        op_d.pc     = in_pc;
        dec_ctrl    = ALU_ADD;
        dec_a       = '0;
        dec_b       = '0;
        shamt_b     = {27'b0, (in_opcode == OPC_OP) ? in_rs2[4:0] : in_imm[4:0]};
        case (in_opcode)
            OPC_OP, OPC_OPIMM: begin
                op_d.kind = K_ALU;
                dec_a     = in_rs1;
                dec_b     = (in_opcode == OPC_OP) ? in_rs2 : in_imm;
                case (in_funct3)
                    3'b000: dec_ctrl = (in_opcode == OPC_OP && in_funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        dec_ctrl = ALU_SLL;
                        dec_b    = shamt_b;
                    end
                    3'b010: begin
                        dec_ctrl  = ALU_SUB;
                        op_d.kind = K_SLT;
                    end
                    3'b011: begin
                        dec_ctrl  = ALU_SUB;
                        op_d.kind = K_SLTU;
                    end
                    3'b100: dec_ctrl = ALU_XOR;
                    3'b101: begin
                        dec_ctrl = in_funct7_5 ? ALU_SRA : ALU_SRL;
                        dec_b    = shamt_b;
                    end
                    3'b110: dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                op_d.kind = K_ALU;
                dec_b     = in_imm;
            end
            OPC_AUIPC: begin
                op_d.kind = K_ALU;
                dec_a     = in_pc;
                dec_b     = in_imm;
            end
            OPC_BRANCH: begin
                if (in_funct3 != 3'b010 && in_funct3 != 3'b011) begin
                    op_d.kind = K_BR;
                    dec_ctrl  = ALU_SUB;
                    dec_a     = in_rs1;
                    dec_b     = in_rs2;
                end
            end
            OPC_JAL: begin
                op_d.kind = K_JAL;
                dec_a     = in_pc;
                dec_b     = LINK_OFFSET;
            end
            OPC_JALR: begin
                if (in_funct3 == 3'b000) begin
                    op_d.kind = K_JALR;
                    dec_a     = in_pc;
                    dec_b     = LINK_OFFSET;
                end
            end
            default: ;
        endcase
    end

    // Signed/unsigned compare from the SUB pass: sign-mismatch decides without looking at the difference.
    assign lt_s = (alu_a[31] ^ alu_b[31]) ? alu_a[31] : alu_out[31];
    assign lt_u = (alu_a[31] ^ alu_b[31]) ? alu_b[31] : alu_out[31];

    always_comb begin
        case (op_q.funct3)
            3'b000:  br_cond = alu_zero;
            3'b001:  br_cond = !alu_zero;
            3'b100:  br_cond = lt_s;
            3'b101:  br_cond = !lt_s;
            3'b110:  br_cond = lt_u;
            default: br_cond = !lt_u;
        endcase
    end

    always_comb begin
        case (op_q.kind)
            K_SLT:   single_res = {31'b0, lt_s};
            K_SLTU:  single_res = {31'b0, lt_u};
            K_ILL:   single_res = '0;
            default: single_res = alu_out;
        endcase
    end

    assign two_pass = (op_q.kind == K_BR) || (op_q.kind == K_JAL) || (op_q.kind == K_JALR);
    assign tgt      = (op_q.kind == K_JALR) ? {alu_out[31:1], 1'b0} : alu_out;

`ifdef EXEC_TRAP_EN
    logic misal;
    assign misal = taken_q && (tgt[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready && (ALLOW_B2B != 0);
            end
            default: ;
        endcase
        accept = in_valid && in_ready;
        case (state)
            IDLE: if (accept) state_d = EX1;
            EX1:  state_d = two_pass ? EX2 : HOLD;
            EX2:  state_d = HOLD;
            HOLD: if (out_ready) state_d = accept ? EX1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= '0;
            alu_ctrl      <= ALU_ADD;
            alu_a         <= '0;
            alu_b         <= '0;
            taken_q       <= 1'b0;
            link_q        <= '0;
            out_result    <= '0;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
            out_illegal   <= 1'b0;
`ifdef EXEC_TRAP_EN
            out_trap      <= 1'b0;
`endif
        end else if (accept) begin
            op_q     <= op_d;
            alu_ctrl <= dec_ctrl;
            alu_a    <= dec_a;
            alu_b    <= dec_b;
        end else if (state == EX1) begin
            if (two_pass) begin
                alu_ctrl <= ALU_ADD;
                alu_a    <= (op_q.kind == K_JALR) ? op_q.rs1 : op_q.pc;
                alu_b    <= op_q.imm;
                taken_q  <= (op_q.kind == K_BR) ? br_cond : 1'b1;
                link_q   <= (op_q.kind == K_BR) ? 32'd0 : alu_out;
            end else begin
                alu_ctrl      <= ALU_ADD;
                alu_a         <= '0;
                alu_b         <= '0;
                out_result    <= single_res;
                out_br_taken  <= 1'b0;
                out_br_target <= '0;
                out_illegal   <= (op_q.kind == K_ILL);
`ifdef EXEC_TRAP_EN
                out_trap      <= 1'b0;
`endif
            end
        end else if (state == EX2) begin
            alu_ctrl      <= ALU_ADD;
            alu_a         <= '0;
            alu_b         <= '0;
            out_br_target <= tgt;
            out_illegal   <= 1'b0;
`ifdef EXEC_TRAP_EN
            // A misaligned redirect becomes a trap: no redirect and no link write.
            out_trap      <= misal;
            out_br_taken  <= taken_q && !misal;
            out_result    <= misal ? 32'd0 : link_q;
`else
            out_br_taken  <= taken_q;
            out_result    <= link_q;
`endif
        end
    end

endmodule

// File: tb/tb_exec_seq.sv
// Directed bench for exec_seq with a behavioural combinational ALU.
module tb_exec_seq;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_zero;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_br_target;
    logic        out_br_taken, out_illegal;
`ifdef EXEC_TRAP_EN
    logic        out_trap;
`endif

    int vectors = 0;
    int miscompares = 0;

    exec_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_br_taken(out_br_taken),
        .out_br_target(out_br_target),
`ifdef EXEC_TRAP_EN
        .out_trap(out_trap),
`endif
        .out_illegal(out_illegal)
    );

    always_comb begin
        case (alu_ctrl)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a | alu_b;
            3'd4:    alu_out = alu_a ^ alu_b;
            3'd5:    alu_out = alu_a << alu_b[4:0];
            3'd6:    alu_out = $signed(alu_a) >>> alu_b[4:0];
            default: alu_out = alu_a >> alu_b[4:0];
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] p);
        in_opcode = opc; in_funct3 = f3; in_funct7_5 = f7;
        in_rs1 = a; in_rs2 = b; in_imm = im; in_pc = p;
    endtask

    // Presents the op, waits for the handshake, then counts edges until out_valid (-1 on timeout).
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p, output int lat);
        int n = 0;
        set_op(opc, f3, f7, a, b, im, p);
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_hold();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL rst_result got %h want 0", out_result); end
        vectors++; if (out_br_taken !== 1'b0) begin miscompares++; $display("FAIL rst_taken got %b want 0", out_br_taken); end
        vectors++; if (out_br_target !== 32'd0) begin miscompares++; $display("FAIL rst_target got %h want 0", out_br_target); end
        vectors++; if (out_illegal !== 1'b0) begin miscompares++; $display("FAIL rst_illegal got %b want 0", out_illegal); end
        vectors++; if (alu_ctrl !== 3'd0) begin miscompares++; $display("FAIL rst_alu_ctrl got %0d want 0", alu_ctrl); end
        vectors++; if ({alu_a, alu_b} !== 64'd0) begin miscompares++; $display("FAIL rst_alu_ab got %h %h want 0 0", alu_a, alu_b); end
`ifdef EXEC_TRAP_EN
        vectors++; if (out_trap !== 1'b0) begin miscompares++; $display("FAIL rst_trap got %b want 0", out_trap); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_idle got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_add();
        int lat;
        out_ready = 1'b1;
        issue(OPC_OP, 3'b000, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL add_latency got %0d want 2", lat); end
        vectors++; if (out_result !== 32'h80000000) begin miscompares++; $display("FAIL add_result got %h want 80000000", out_result); end
        vectors++; if (out_br_taken !== 1'b0) begin miscompares++; $display("FAIL add_taken got %b want 0", out_br_taken); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL add_hold_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_valid_drop got %b want 0", out_valid); end
    endtask

    task automatic test_branch();
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic        exp_tk;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin f3 = 3'b000; a = 32'd5;        b = 32'd5; exp_tk = 1'b1; end
                1: begin f3 = 3'b001; a = 32'd5;        b = 32'd5; exp_tk = 1'b0; end
                2: begin f3 = 3'b100; a = 32'hFFFFFFFF; b = 32'd1; exp_tk = 1'b1; end
                3: begin f3 = 3'b110; a = 32'hFFFFFFFF; b = 32'd1; exp_tk = 1'b0; end
                4: begin f3 = 3'b101; a = 32'hFFFFFFFF; b = 32'd1; exp_tk = 1'b0; end
                default: begin f3 = 3'b111; a = 32'hFFFFFFFF; b = 32'd1; exp_tk = 1'b1; end
            endcase
            issue(OPC_BRANCH, f3, 1'b0, a, b, 32'hFFFFFFF8, 32'h100, lat);
            vectors++; if (lat !== 3) begin miscompares++; $display("FAIL br%0d_latency got %0d want 3", i, lat); end
            vectors++; if (out_br_taken !== exp_tk) begin miscompares++; $display("FAIL br%0d_taken got %b want %b", i, out_br_taken, exp_tk); end
            vectors++; if (out_br_target !== 32'hF8) begin miscompares++; $display("FAIL br%0d_target got %h want f8", i, out_br_target); end
            vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL br%0d_result got %h want 0", i, out_result); end
            release_hold();
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7, exp_ill;
        logic [31:0] a, b, im, p, exp;
        int          lat;
        for (int i = 0; i < 13; i++) begin
            f7 = 1'b0; a = 32'd0; b = 32'd0; im = 32'd0; p = 32'd0; exp_ill = 1'b0;
            case (i)
                0:  begin opc = OPC_OP;    f3 = 3'b010; a = 32'h80000000; b = 32'd1;        exp = 32'd1; end
                1:  begin opc = OPC_OP;    f3 = 3'b011; a = 32'h80000000; b = 32'd1;        exp = 32'd0; end
                2:  begin opc = OPC_OP;    f3 = 3'b010; a = 32'h7FFFFFFF; b = 32'hFFFFFFFF; exp = 32'd0; end
                3:  begin opc = OPC_OP;    f3 = 3'b011; a = 32'h7FFFFFFF; b = 32'hFFFFFFFF; exp = 32'd1; end
                4:  begin opc = OPC_OPIMM; f3 = 3'b101; f7 = 1'b1; a = 32'h80000000; im = 32'h404; exp = 32'hF8000000; end
                5:  begin opc = OPC_OP;    f3 = 3'b000; f7 = 1'b1; a = 32'd5; b = 32'd7; exp = 32'hFFFFFFFE; end
                6:  begin opc = OPC_LUI;   f3 = 3'b000; a = 32'hDEAD; im = 32'h12345000; exp = 32'h12345000; end
                7:  begin opc = OPC_AUIPC; f3 = 3'b000; p = 32'hFFFFF000; im = 32'h2000; exp = 32'h00001000; end
                8:  begin opc = OPC_OPIMM; f3 = 3'b010; a = 32'hFFFFFFFE; im = 32'hFFFFFFFF; exp = 32'd1; end
                9:  begin opc = OPC_OP;    f3 = 3'b001; a = 32'd1; b = 32'hFFFFFFE5; exp = 32'h20; end
                10: begin opc = OPC_OPIMM; f3 = 3'b111; a = 32'hF0F0; im = 32'hFF00; exp = 32'hF000; end
                11: begin opc = 7'h7F;     f3 = 3'b000; a = 32'd9; b = 32'd9; exp = 32'd0; exp_ill = 1'b1; end
                default: begin opc = OPC_BRANCH; f3 = 3'b010; a = 32'd5; b = 32'd5; exp = 32'd0; exp_ill = 1'b1; end
            endcase
            issue(opc, f3, f7, a, b, im, p, lat);
            vectors++; if (lat !== 2) begin miscompares++; $display("FAIL alu%0d_latency got %0d want 2", i, lat); end
            vectors++; if (out_result !== exp) begin miscompares++; $display("FAIL alu%0d_result got %h want %h", i, out_result, exp); end
            vectors++; if (out_illegal !== exp_ill) begin miscompares++; $display("FAIL alu%0d_illegal got %b want %b", i, out_illegal, exp_ill); end
            vectors++; if (out_br_taken !== 1'b0 || out_br_target !== 32'd0) begin miscompares++; $display("FAIL alu%0d_redirect got %b %h want 0 0", i, out_br_taken, out_br_target); end
            release_hold();
        end
    endtask

    task automatic test_jumps();
        int lat;
        issue(OPC_JALR, 3'b000, 1'b0, 32'h1003, 32'd0, 32'd0, 32'h200, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL jalr_latency got %0d want 3", lat); end
        vectors++; if (out_br_target !== 32'h1002) begin miscompares++; $display("FAIL jalr_target got %h want 1002", out_br_target); end
`ifdef EXEC_TRAP_EN
        vectors++; if (out_trap !== 1'b1) begin miscompares++; $display("FAIL jalr_trap got %b want 1", out_trap); end
        vectors++; if (out_br_taken !== 1'b0) begin miscompares++; $display("FAIL jalr_taken got %b want 0", out_br_taken); end
        vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL jalr_result got %h want 0", out_result); end
`else
        vectors++; if (out_br_taken !== 1'b1) begin miscompares++; $display("FAIL jalr_taken got %b want 1", out_br_taken); end
        vectors++; if (out_result !== 32'h204) begin miscompares++; $display("FAIL jalr_result got %h want 204", out_result); end
`endif
        release_hold();
        issue(OPC_JAL, 3'b000, 1'b0, 32'd0, 32'd0, 32'd8, 32'hFFFFFFFC, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL jal_latency got %0d want 3", lat); end
        vectors++; if (out_result !== 32'd0) begin miscompares++; $display("FAIL jal_link_wrap got %h want 0", out_result); end
        vectors++; if (out_br_target !== 32'd4) begin miscompares++; $display("FAIL jal_target got %h want 4", out_br_target); end
        vectors++; if (out_br_taken !== 1'b1) begin miscompares++; $display("FAIL jal_taken got %b want 1", out_br_taken); end
`ifdef EXEC_TRAP_EN
        vectors++; if (out_trap !== 1'b0) begin miscompares++; $display("FAIL jal_trap got %b want 0", out_trap); end
`endif
        release_hold();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(OPC_OP, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL bp_latency got %0d want 2", lat); end
        set_op(OPC_OP, 3'b100, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            vectors++; if (out_valid !== 1'b1 || out_result !== 32'd7) begin miscompares++; $display("FAIL bp_hold%0d got valid=%b result=%h want 1 7", c, out_valid, out_result); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready%0d got %b want 0", c, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_ex1_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'h0FF0) begin miscompares++; $display("FAIL b2b_result got valid=%b result=%h want 1 0ff0", out_valid, out_result); end
        release_hold();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        set_op(OPC_JAL, 3'b000, 1'b0, 32'd0, 32'd0, 32'h40, 32'h300);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++; if (alu_a !== 32'h300 || alu_b !== 32'h40) begin miscompares++; $display("FAIL rmid_ex2_operands got %h %h want 300 40", alu_a, alu_b); end
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_async got valid=%b ready=%b want 0 1", out_valid, in_ready); end
        vectors++; if (alu_a !== 32'd0 || out_result !== 32'd0) begin miscompares++; $display("FAIL rmid_clear got alu_a=%h result=%h want 0 0", alu_a, out_result); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_after got valid=%b ready=%b want 0 1", out_valid, in_ready); end
        issue(OPC_OP, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, lat);
        vectors++; if (lat !== 2 || out_result !== 32'd3) begin miscompares++; $display("FAIL rmid_next got lat=%0d result=%h want 2 3", lat, out_result); end
        vectors++; if (out_br_taken !== 1'b0) begin miscompares++; $display("FAIL rmid_no_jal got taken=%b want 0", out_br_taken); end
        release_hold();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_op(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        test_reset();
        test_add();
        test_branch();
        test_alu_ops();
        test_jumps();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_seq.md
Name: exec_seq

Overview:
- Execute-stage sequencer. It is the initiator side of the combinational ALU: it produces the ALU operation code and operands, and consumes the ALU result and zero flag.
- Accepts one decoded RV32I integer/branch/jump op per valid/ready handshake.
- Runs one or two ALU passes per op, then holds the result, branch decision and target until downstream accepts.
- Sits between the decode register and the writeback/PC-select logic.

Parameters:
LINK_OFFSET, 4, constant added to pc to form the JAL/JALR link value
ALLOW_B2B, 1, 1 = accept a new op in the HOLD cycle in which out_ready=1; 0 = accept only in IDLE

Ports:
clk  in  1  clock, all state on the rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  decoded op available
in_ready  out  1  sequencer can accept an op
in_opcode  in  7  RV32I opcode[6:0]
in_funct3  in  3  funct3
in_funct7_5  in  1  instr[30]
in_rs1  in  32  rs1 value
in_rs2  in  32  rs2 value
in_imm  in  32  sign-extended immediate
in_pc  in  32  instruction pc
alu_ctrl  out  3  ALU op code, encodings from macro.vh (ADD, SUB, AND, OR, XOR, SLL, SRA, SRL)
alu_a  out  32  ALU operand A
alu_b  out  32  ALU operand B
alu_out  in  32  ALU result, combinational from alu_ctrl/alu_a/alu_b
alu_zero  in  1  ALU zero flag, valid only when alu_ctrl=SUB
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_result  out  32  rd writeback value (link value for jumps, 0 for branches)
out_br_taken  out  1  redirect PC (taken branch, JAL, JALR)
out_br_target  out  32  redirect target
out_illegal  out  1  unsupported opcode/funct

Behaviour:
- FSM states: IDLE, EX1, EX2, HOLD. Reset state is IDLE.
- Reset values: out_valid=0, out_result=0, out_br_taken=0, out_br_target=0, out_illegal=0, alu_ctrl=ADD, alu_a=0, alu_b=0.
- in_ready=1 in IDLE. in_ready=1 in HOLD only when out_ready=1 and ALLOW_B2B=1. in_ready=0 otherwise.
- Accept occurs when in_valid & in_ready. All in_* fields are latched; next state is EX1.
- alu_ctrl/alu_a/alu_b are registered and driven from the latched fields. alu_out is sampled at the end of the same state.
- EX1 pass by op:
  - OP/OP-IMM arithmetic: ADD; SUB only for OP with funct7_5=1; AND, OR, XOR.
  - Shifts: SLL; SRL or SRA selected by funct7_5. alu_b = {27'b0, operand[4:0]}.
  - Result = alu_out, then go to HOLD.
- SLT/SLTI/SLTU/SLTIU: SUB pass.
  - lt_s = (a[31]^b[31]) ? a[31] : alu_out[31]
  - lt_u = (a[31]^b[31]) ? b[31] : alu_out[31]
  - Result = {31'b0, lt}, then go to HOLD. The ALU slt/sltu flags are not used.
- LUI: ADD 0+imm. AUIPC: ADD pc+imm. Both go to HOLD.
- BRANCH (funct3 000,001,100,101,110,111): EX1 = SUB rs1-rs2.
  - taken computed from alu_zero/lt_s/lt_u and latched; go to EX2.
  - EX2 = ADD pc+imm gives the target. Result = 0.
- JAL: EX1 = ADD pc+LINK_OFFSET gives the result. EX2 = ADD pc+imm gives the target. taken=1.
- JALR: EX1 = ADD pc+LINK_OFFSET. EX2 = ADD rs1+imm, target bit0 forced to 0. taken=1.
- Unsupported opcode or funct3: out_illegal=1, result 0, taken 0. Single pass with ALU idle at ADD 0+0.
- Latency from accept edge to out_valid=1: 2 cycles for single-pass ops, 3 cycles for two-pass ops.
- HOLD: out_valid=1; all out_* held stable until out_ready.
  - On out_ready: go to IDLE, or to EX1 if a new op is accepted in the same cycle.
  - out_valid deasserts the cycle after the handshake unless a new op completes.
- Non-branch ops force out_br_taken=0 and out_br_target=0.
- Arithmetic wraps modulo 2^32, e.g. pc 0xFFFFFFFC + 4 = 0.
- Async reset mid-op: the op is dropped, the FSM goes to IDLE and outputs take reset values immediately. No partial result is emitted.
- in_valid during EX1/EX2 is ignored (in_ready=0). The upstream must hold it.

Optional Feature:
- Macro EXEC_TRAP_EN.
- Defined: adds output port out_trap (1 bit, reset 0). out_trap=1 in HOLD when out_br_taken=1 and out_br_target[1:0]!=0.
  - When out_trap=1, out_br_taken is forced to 0 and out_result is forced to 0 (no link write).
- Undefined: no out_trap port; misaligned targets pass through unchanged.

Test Plan:
- ADD rs1=0x7FFFFFFF rs2=1, out_ready=1 -> out_valid at accept+2, out_result=0x80000000, taken=0.
- SLT rs1=0x80000000 rs2=1 -> result 1. SLTU with same operands -> result 0. Check the overflow case rs1=0x7FFFFFFF rs2=0xFFFFFFFF: SLT -> 0, SLTU -> 1.
- BEQ rs1=rs2=5, pc=0x100, imm=-8 -> out_valid at accept+3, taken=1, target=0xF8, result=0. BNE with the same operands -> taken=0.
- JALR pc=0x200 rs1=0x1003 imm=0 -> result=0x204, target=0x1002, taken=1. With EXEC_TRAP_EN defined -> out_trap=1, taken=0.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable and in_ready=0. Then out_ready=1 with in_valid=1 and ALLOW_B2B=1 -> accepted the same cycle, next result at +2.
- Assert rst during EX2 of a JAL -> out_valid=0 and in_ready=1 the cycle after release; the next op completes normally.
